// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding decode.
// Holds the PC, issues one instruction-memory request at a time, registers the
// returned word and presents it to decode with a valid/ready handshake.
// Branch/jump redirects load a new PC and flush any in-flight fetch.
// Optional build macro IFETCH_PERF_EN adds fetch/stall performance counters.
module instr_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_redir_pc;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_instr_valid;
    logic            w_vld_nxt;
    logic            w_capture;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;

    // Redirect targets are forced word aligned.
    assign w_redir_pc = redirect_pc & ~XLEN'(3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath controls; a redirect overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_vld_nxt   = r_instr_valid;
        w_capture   = 1'b0;
        if (redirect_valid) begin
            w_pc_nxt  = w_redir_pc;
            w_vld_nxt = 1'b0;
            case (r_state)
                S_IDLE, S_FULL: w_state_nxt = S_REQ;
                // The request going out this cycle carries the old PC, so its
                // response must be thrown away.
                S_REQ: begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = 1'b1;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ:  w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = S_REQ;
                        end else begin
                            w_capture   = 1'b1;
                            w_vld_nxt   = 1'b1;
                            w_pc_nxt    = r_pc + XLEN'(4);
                            w_state_nxt = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (id_ready) begin
                        w_vld_nxt   = 1'b0;
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // PC, drop flag and the registered instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_instr_valid <= w_vld_nxt;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    // Fields read as zero when nothing is live so decode sees a no-op opcode.
    assign opcode = r_instr_valid ? r_instr[6:0]   : 7'd0;
    assign funct3 = r_instr_valid ? r_instr[14:12] : 3'd0;
    assign funct7 = r_instr_valid ? r_instr[31:25] : 7'd0;
    assign rd     = r_instr_valid ? r_instr[11:7]  : 5'd0;
    assign rs1    = r_instr_valid ? r_instr[19:15] : 5'd0;
    assign rs2    = r_instr_valid ? r_instr[24:20] : 5'd0;

`ifdef IFETCH_PERF_EN
    logic w_stall;
    assign w_stall = (r_state == S_FULL) && !id_ready;

    // Count accepted words and decode back-pressure cycles; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_capture) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (w_stall)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small latency-programmable memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt = 0;
    logic [31:0] req_addr = 32'h0;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Address-dependent contents; address 0 holds sub x0,x0,x0.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h4000_0033 ^ {a[15:0], 16'h0};
    endfunction

    // Memory model: answers each request after 'lat' cycles, one-cycle valid pulse.
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(req_addr);
                end
            end
            if (imem_req) begin
                cnt = lat;
                req_addr = imem_addr;
            end
        end
    end

    task automatic wait_req(output int n, output bit to);
        n = 0; to = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); n++;
            if (imem_req) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_valid(output int n, output bit to);
        n = 0; to = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); n++;
            if (instr_valid) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++; $display("FAIL reset_outputs got req=%b addr=%h v=%b instr=%h pc=%h", imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        checks++;
        if ({opcode, funct3, funct7, rd, rs1, rs2} !== 32'h0) begin
            errors++; $display("FAIL reset_fields got op=%h f3=%h f7=%h, required 0", opcode, funct3, funct7);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_seq();
        int n, nv; bit to, tov;
        wait_req(n, to);
        checks++;
        if (to || n != 1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got to=%b n=%0d addr=%h, required n=1 addr=0", to, n, imem_addr);
        end
        wait_valid(nv, tov);
        checks++;
        if (tov || nv != 2 || instr_pc !== 32'h0 || instr !== 32'h4000_0033) begin
            errors++; $display("FAIL first_instr got to=%b n=%0d pc=%h instr=%h, required n=2 pc=0 instr=40000033", tov, nv, instr_pc, instr);
        end
        checks++;
        if ({opcode, funct3, funct7, rd, rs1, rs2} !== {7'h33, 3'h0, 7'h20, 5'h0, 5'h0, 5'h0}) begin
            errors++; $display("FAIL sub_fields got op=%h f3=%h f7=%h rd=%h rs1=%h rs2=%h", opcode, funct3, funct7, rd, rs1, rs2);
        end
        for (int k = 1; k <= 2; k++) begin
            wait_req(n, to);
            checks++;
            if (to || (n + nv) != 3 || imem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL seq_req%0d got to=%b gap=%0d addr=%h, required gap=3 addr=%h", k, to, n + nv, imem_addr, 4 * k);
            end
            wait_valid(nv, tov);
            checks++;
            if (tov || instr_pc !== 32'(4 * k) || instr !== mem_word(32'(4 * k))) begin
                errors++; $display("FAIL seq_instr%0d got pc=%h instr=%h, required pc=%h instr=%h", k, instr_pc, instr, 4 * k, mem_word(32'(4 * k)));
            end
            if (k == 1) begin
                checks++;
                if (rs1 !== 5'd8) begin
                    errors++; $display("FAIL rs1_field got %0d, required 8", rs1);
                end
            end
        end
    endtask

    task automatic test_stall();
        int n, nv; bit to, tov;
        logic [31:0] w;
        wait_req(n, to);
        id_ready = 1'b0;
        wait_valid(nv, tov);
        w = instr;
        checks++;
        if (tov || instr_pc !== 32'hC) begin
            errors++; $display("FAIL stall_fill got to=%b pc=%h, required pc=0000000c", tov, instr_pc);
        end
`ifdef IFETCH_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd4 || perf_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_pre got fetch=%0d stall=%0d, required 4 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (!instr_valid || instr !== w || imem_req) begin
                errors++; $display("FAIL stall_hold%0d got v=%b instr=%h req=%b, required v=1 instr=%h req=0", i, instr_valid, instr, imem_req, w);
            end
        end
`ifdef IFETCH_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd5) begin
            errors++; $display("FAIL perf_stall got %0d, required 5", perf_stall_cnt);
        end
`endif
        id_ready = 1'b1;
        wait_req(n, to);
        checks++;
        if (to || n != 1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL stall_release got n=%0d addr=%h, required n=1 addr=00000010", n, imem_addr);
        end
        wait_valid(nv, tov);
    endtask

    task automatic test_redirect_wait();
        int n, nv; bit to, tov;
        lat = 3;
        wait_req(n, to);
        checks++;
        if (to || imem_addr !== 32'h14) begin
            errors++; $display("FAIL rw_req got addr=%h, required 00000014", imem_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || opcode !== 7'h0 || funct7 !== 7'h0) begin
            errors++; $display("FAIL rw_flush got v=%b op=%h f7=%h, required 0", instr_valid, opcode, funct7);
        end
        wait_req(n, to);
        checks++;
        if (to || n != 1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rw_target got n=%0d addr=%h v=%b, required n=1 addr=00000100 v=0", n, imem_addr, instr_valid);
        end
        wait_valid(nv, tov);
        checks++;
        if (tov || nv != 4 || instr_pc !== 32'h100 || instr !== 32'h4100_0033) begin
            errors++; $display("FAIL rw_instr got n=%0d pc=%h instr=%h, required n=4 pc=00000100 instr=41000033", nv, instr_pc, instr);
        end
    endtask

    task automatic test_redirect_same_valid();
        int n, nv; bit to, tov;
        lat = 2;
        wait_req(n, to);
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (!imem_req || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rv_discard got req=%b addr=%h v=%b, required req=1 addr=00000200 v=0", imem_req, imem_addr, instr_valid);
        end
        wait_valid(nv, tov);
        checks++;
        if (tov || nv != 3 || instr_pc !== 32'h200) begin
            errors++; $display("FAIL rv_instr got n=%0d pc=%h, required n=3 pc=00000200", nv, instr_pc);
        end
    endtask

    task automatic test_redirect_full_wrap();
        int n, nv; bit to, tov;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || !imem_req || imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL rf_flush got v=%b req=%b addr=%h, required v=0 req=1 addr=fffffffc", instr_valid, imem_req, imem_addr);
        end
        wait_valid(nv, tov);
        checks++;
        if (tov || instr_pc !== 32'hFFFF_FFFC || instr !== 32'hBFFC_0033) begin
            errors++; $display("FAIL rf_instr got pc=%h instr=%h, required fffffffc bffc0033", instr_pc, instr);
        end
        wait_req(n, to);
        checks++;
        if (to || imem_addr !== 32'h0) begin
            errors++; $display("FAIL pc_wrap got addr=%h, required 00000000", imem_addr);
        end
    endtask

    task automatic test_reset_midwait();
        int n, nv; bit to, tov;
        lat = 3;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc, opcode} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 7'h0}) begin
            errors++; $display("FAIL async_reset got req=%b addr=%h v=%b instr=%h pc=%h", imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
`ifdef IFETCH_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_reset got fetch=%0d stall=%0d, required 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        wait_req(n, to);
        checks++;
        if (to || n != 1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL post_reset_req got n=%0d addr=%h, required n=1 addr=0", n, imem_addr);
        end
        wait_valid(nv, tov);
        checks++;
        if (tov || nv != 4 || instr_pc !== 32'h0 || instr !== 32'h4000_0033) begin
            errors++; $display("FAIL post_reset_instr got n=%0d pc=%h instr=%h, required n=4 pc=0 instr=40000033", nv, instr_pc, instr);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect_wait();
        test_redirect_same_valid();
        test_redirect_full_wrap();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
